// File: rtl/debug_display_unit.sv
// -----------------------------------------------------------------------------
// debug_display_unit
//   Board-side debug stage placed around a multicycle CPU and its memory.
//   It drives the CPU's run enable and probe address. It lets the user
//   single-step, run continuously, or move the probe address up and down.
//   The probed register or memory word is shown on an 8-digit multiplexed
//   seven-segment display, and the PC is shown on the LEDs.
//
//   Optional feature macro: DEBOUNCE_EN
//     defined   : each synchronised button must hold a new level for
//                 DEBOUNCE_CYCLES clocks before the filtered level follows it.
//     undefined : buttons feed the edge detector straight from the
//                 synchroniser (use this setting for simulation).
//
// Ports
//   clock        in   system clock
//   reset        in   asynchronous, active-low reset
//   cont         in   switch, 1 = continuous run
//   step         in   button, execute one instruction
//   inc, dec     in   buttons, probe address +1 / -1 (with wrap)
//   mem_sel      in   switch, 1 = show ProbeMemData, 0 = show ProbeRegData
//   ProbePC      in   CPU program counter
//   ProbeRegData in   register-file word at ProbeAddress
//   ProbeMemData in   memory word at ProbeAddress
//   run          out  CPU run enable (registered)
//   ProbeAddress out  probe address sent to the CPU and the memory
//   an           out  digit anodes, one-hot, active-low
//   seg          out  segments {g..a}, active-low hex glyph
//   led          out  {ProbeAddress zero-extended to 8 bits, ProbePC[9:2]}
// -----------------------------------------------------------------------------
module debug_display_unit #(
  parameter int DIGIT           = 32,
  parameter int DEBUGSIZE       = 8,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int SCAN_DIV        = 4,
  parameter int STEP_TIMEOUT    = 255
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 cont,
  input  logic                 step,
  input  logic                 inc,
  input  logic                 dec,
  input  logic                 mem_sel,
  input  logic [DIGIT-1:0]     ProbePC,
  input  logic [DIGIT-1:0]     ProbeRegData,
  input  logic [DIGIT-1:0]     ProbeMemData,
  output logic                 run,
  output logic [DEBUGSIZE-1:0] ProbeAddress,
  output logic [7:0]           an,
  output logic [6:0]           seg,
  output logic [15:0]          led
);

  localparam int TW = $clog2(STEP_TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, CONT, STEP} state_t;

  // Bit order of the synchronised inputs: {mem_sel, cont, dec, inc, step}.
  logic [4:0] sync_meta, sync_q;
  logic       cont_s, mem_sel_s;
  logic [2:0] btn_lvl;    // {dec, inc, step} level seen by the edge detector
  logic [2:0] btn_prev;
  logic [2:0] btn_pulse;  // one-clock pulse per press

  state_t              state;
  logic [TW-1:0]       tcnt;
  logic [DIGIT-1:0]    pc0;
  logic [SCAN_DIV-1:0] prescale;
  logic [2:0]          digit_idx;
  logic [DIGIT-1:0]    word;
  logic [3:0]          nibble;

  assign cont_s    = sync_q[3];
  assign mem_sel_s = sync_q[4];

  // NOTE: sequential state uses non-blocking assignments, so every flop
  // samples the values that held before the edge, whatever the statement order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_meta <= '0;
      sync_q    <= '0;
    end else begin
      sync_meta <= {mem_sel, cont, dec, inc, step};
      sync_q    <= sync_meta;
    end
  end

`ifdef DEBOUNCE_EN
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [2:0]    btn_filt;
  logic [DW-1:0] db_cnt [3];

  // The counter runs only while the synchronised level disagrees with the
  // filtered level. Any agreement restarts it, so a glitch never gets through.
  // NOTE: this small counter array is reset like any other state. Only true
  // RAM arrays are left out of the reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      btn_filt <= '0;
      for (int i = 0; i < 3; i++) db_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (sync_q[i] == btn_filt[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
          btn_filt[i] <= sync_q[i];
          db_cnt[i]   <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + DW'(1);
        end
      end
    end
  end

  assign btn_lvl = btn_filt;
`else
  assign btn_lvl = sync_q[2:0];
`endif

  // The pulse is registered. This gives three clocks from the pin edge to the pulse.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      btn_prev  <= '0;
      btn_pulse <= '0;
    end else begin
      btn_prev  <= btn_lvl;
      btn_pulse <= btn_lvl & ~btn_prev;
    end
  end

  // The probe address moves in every FSM state. Opposite presses that land
  // in the same cycle cancel each other.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ProbeAddress <= '0;
    end else begin
      case ({btn_pulse[1], btn_pulse[2]})
        2'b10:   ProbeAddress <= ProbeAddress + 1'b1;
        2'b01:   ProbeAddress <= ProbeAddress - 1'b1;
        default: ProbeAddress <= ProbeAddress;
      endcase
    end
  end

  // Run-control FSM. run is updated together with state, so it already
  // reflects the state being entered.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      run   <= 1'b0;
      tcnt  <= '0;
      pc0   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cont_s) begin
            state <= CONT;
            run   <= 1'b1;
          end else if (btn_pulse[0]) begin
            state <= STEP;
            run   <= 1'b1;
            pc0   <= ProbePC;
            tcnt  <= '0;
          end
        end
        CONT: begin
          if (!cont_s) begin
            state <= IDLE;
            run   <= 1'b0;
          end
        end
        STEP: begin
          tcnt <= tcnt + TW'(1);
          // Exiting when the incremented count reaches the limit caps run at
          // STEP_TIMEOUT clocks.
          if (cont_s) begin
            state <= CONT;
          end else if ((ProbePC != pc0) ||
                       ((tcnt + TW'(1)) == TW'(STEP_TIMEOUT))) begin
            state <= IDLE;
            run   <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          run   <= 1'b0;
        end
      endcase
    end
  end

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h40;  4'h1: hex7 = 7'h79;
      4'h2: hex7 = 7'h24;  4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;  4'h5: hex7 = 7'h12;
      4'h6: hex7 = 7'h02;  4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;  4'h9: hex7 = 7'h10;
      4'hA: hex7 = 7'h08;  4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;  4'hD: hex7 = 7'h21;
      4'hE: hex7 = 7'h06;  default: hex7 = 7'h0E;
    endcase
  endfunction

  // NOTE: every always_comb output gets a default value first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    word   = ProbeRegData;
    if (mem_sel_s) word = ProbeMemData;
    nibble = word[{digit_idx, 2'b00} +: 4];
  end

  // Display scan and LEDs. The data word is sampled live on every clock.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      prescale  <= '0;
      digit_idx <= '0;
      an        <= 8'hFF;
      seg       <= 7'h7F;
      led       <= '0;
    end else begin
      prescale <= prescale + 1'b1;
      if (prescale == '1) digit_idx <= digit_idx + 3'd1;
      an  <= ~(8'b1 << digit_idx);
      seg <= hex7(nibble);
      led <= {8'(ProbeAddress), ProbePC[9:2]};
    end
  end

endmodule

// File: tb/tb_debug_display_unit.sv
// -----------------------------------------------------------------------------
// tb_debug_display_unit
//   Self-checking bench for debug_display_unit in the default build (no
//   debounce filter). Each stimulus task pushes its expected response into a
//   queue. Run bursts and probe-address changes are checked by separate
//   monitor processes, and the display is checked against a hex glyph table.
// -----------------------------------------------------------------------------
module tb_debug_display_unit;

  localparam int STEP_TIMEOUT = 255;

  logic        clock = 1'b0;
  logic        reset;
  logic        cont, step, inc, dec, mem_sel;
  logic [31:0] ProbePC, ProbeRegData, ProbeMemData;
  logic        run;
  logic [7:0]  ProbeAddress;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic [15:0] led;

  debug_display_unit #(
    .DIGIT(32), .DEBUGSIZE(8), .DEBOUNCE_CYCLES(16), .SCAN_DIV(4),
    .STEP_TIMEOUT(STEP_TIMEOUT)
  ) dut (
    .clock(clock), .reset(reset), .cont(cont), .step(step), .inc(inc),
    .dec(dec), .mem_sel(mem_sel), .ProbePC(ProbePC),
    .ProbeRegData(ProbeRegData), .ProbeMemData(ProbeMemData), .run(run),
    .ProbeAddress(ProbeAddress), .an(an), .seg(seg), .led(led)
  );

  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;

  int run_q[$];   // expected length, in clocks, of each run burst
  int addr_q[$];  // expected probe address after each effective press
  int exp_addr;   // reference probe address

  // Active-low glyphs {g,f,e,d,c,b,a} for the hex digits 0-F.
  logic [6:0] glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02,
                             7'h78, 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21,
                             7'h06, 7'h0E};

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Monitor: measures each run burst and compares it with the queue.
  initial begin
    int  hi_cnt;
    bit  run_prev;
    hi_cnt   = 0;
    run_prev = 1'b0;
    forever begin
      @(negedge clock);
      if (reset !== 1'b1) begin
        hi_cnt   = 0;
        run_prev = 1'b0;
      end else begin
        if (run === 1'b1) begin
          hi_cnt++;
        end else if (run_prev) begin
          if (run_q.size() == 0) check("unexpected_run_burst", hi_cnt, 0);
          else check("run_length", hi_cnt, run_q.pop_front());
          hi_cnt = 0;
        end
        run_prev = (run === 1'b1);
      end
    end
  end

  // Monitor: each change of ProbeAddress must match the next expected value.
  initial begin
    logic [7:0] prev;
    prev = 8'h00;
    forever begin
      @(negedge clock);
      if (reset !== 1'b1) begin
        prev = 8'h00;
      end else if (ProbeAddress !== prev) begin
        if (addr_q.size() == 0) check("unexpected_addr_change", ProbeAddress, prev);
        else check("probe_addr", ProbeAddress, addr_q.pop_front());
        prev = ProbeAddress;
      end
    end
  end

  // One press: up for two clocks, then enough low time for the next edge.
  task automatic addr_press(input bit i, input bit d);
    if (i && !d) begin
      exp_addr = (exp_addr + 1) % 256;
      addr_q.push_back(exp_addr);
    end else if (d && !i) begin
      exp_addr = (exp_addr + 255) % 256;
      addr_q.push_back(exp_addr);
    end
    inc = i;
    dec = d;
    tick(2);
    inc = 1'b0;
    dec = 1'b0;
    tick(5);
  endtask

  // Single step. The CPU model moves the PC d clocks after run rises, and the
  // FSM sees the move one clock later. With no PC move, run stops at the timeout.
  task automatic step_episode(input int d, input bit timeout, input bit second);
    bit ok;
    run_q.push_back(timeout ? STEP_TIMEOUT : d + 1);
    step = 1'b1;
    tick(3);
    step = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (run === 1'b1) begin ok = 1'b1; break; end
    end
    check("step_run_rise", ok, 1'b1);
    if (!timeout) begin
      for (int k = 0; k < d; k++) begin
        @(posedge clock);
        #1;
        if (second && k == 0) step = 1'b1;
        if (second && k == 3) step = 1'b0;
      end
      ProbePC = ProbePC + 32'(4 * (1 + $urandom_range(0, 7)));
    end
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clock);
      if (run === 1'b0) begin ok = 1'b1; break; end
    end
    check("step_run_fall", ok, 1'b1);
    tick(15);
  endtask

  // Continuous run: cont is high for n clocks, with a step press in the middle
  // that must have no effect.
  task automatic cont_episode(input int n);
    run_q.push_back(n);
    cont = 1'b1;
    tick(5);
    step = 1'b1;
    tick(3);
    step = 1'b0;
    tick(n - 8);
    cont = 1'b0;
    tick(20);
  endtask

  // Scan the display through all eight digits and compare each glyph. Digit 1
  // is watched from its first clock, to measure how long one digit is held.
  task automatic disp_test(input bit ms, input logic [31:0] w);
    logic [7:0] want_an;
    logic [3:0] nib;
    bit         ok;
    int         dwell;
    mem_sel = ms;
    if (ms) begin ProbeMemData = w; ProbeRegData = $urandom; end
    else    begin ProbeRegData = w; ProbeMemData = $urandom; end
    tick(4);
    for (int d = 0; d < 8; d++) begin
      want_an = ~(8'h01 << d);
      nib     = w[4*d +: 4];
      ok      = 1'b0;
      for (int i = 0; i < 200; i++) begin
        @(negedge clock);
        if (an === want_an) begin ok = 1'b1; break; end
      end
      check("an_digit_select", ok, 1'b1);
      check("seg_glyph", seg, glyph[nib]);
      if (d == 1 && ok) begin
        dwell = 1;
        for (int i = 0; i < 40; i++) begin
          @(negedge clock);
          if (an !== want_an) break;
          dwell++;
        end
        check("digit_dwell", dwell, 16);
      end
    end
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [15:0] exp_led;
    int          d;
    reset = 1'b0;
    cont = 1'b0; step = 1'b0; inc = 1'b0; dec = 1'b0; mem_sel = 1'b0;
    ProbePC = 32'h0; ProbeRegData = 32'h0; ProbeMemData = 32'h0;
    exp_addr = 0;
    #20;
    check("reset_run", run, 1'b0);
    check("reset_addr", ProbeAddress, 8'h00);
    check("reset_an", an, 8'hFF);
    check("reset_seg", seg, 7'h7F);
    check("reset_led", led, 16'h0000);
    @(posedge clock);
    #1;
    reset = 1'b1;
    tick(5);
    check("idle_run", run, 1'b0);

    // Single stepping: the documented case, then a second press that must be
    // ignored, then a timeout, then random PC-commit delays.
    step_episode(6, 1'b0, 1'b0);
    step_episode(8 + $urandom_range(0, 12), 1'b0, 1'b1);
    step_episode(0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      d = 1 + $urandom_range(0, 29);
      step_episode(d, 1'b0, d >= 8);
    end

    cont_episode(40);
    cont_episode(20 + $urandom_range(0, 30));

    // Probe address: wrap both ways, then opposite presses in the same cycle.
    addr_press(1'b0, 1'b1);
    check("addr_dec_wrap", ProbeAddress, 8'hFF);
    addr_press(1'b1, 1'b0);
    check("addr_inc_wrap", ProbeAddress, 8'h00);
    addr_press(1'b1, 1'b0);
    addr_press(1'b1, 1'b1);
    check("addr_inc_dec_same_cycle", ProbeAddress, 8'(exp_addr));
    for (int i = 0; i < 20; i++) begin
      addr_press($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
    end
    ProbePC = $urandom;
    tick(3);
    exp_led = {8'(exp_addr), ProbePC[9:2]};
    check("led_value", led, exp_led);

    disp_test(1'b0, 32'h12345678);
    disp_test(1'b1, 32'hDEADBEEF);
    disp_test($urandom_range(0, 1) == 1, $urandom);

    // Reset in the middle of a continuous run must drop run at once.
    cont = 1'b1;
    tick(8);
    check("cont_run_high", run, 1'b1);
    reset = 1'b0;
    #1;
    check("async_reset_run", run, 1'b0);
    check("async_reset_addr", ProbeAddress, 8'h00);
    exp_addr = 0;
    addr_q.delete();
    cont = 1'b0;
    tick(2);
    reset = 1'b1;
    tick(10);
    check("post_reset_run", run, 1'b0);

    tick(20);
    check("run_queue_drained", run_q.size(), 0);
    check("addr_queue_drained", addr_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
